// File: rtl/fp_mc_seq_pkg.sv
// Shared definitions for the multi-cycle FP sequencer: state encoding,
// canonical NaN, fflags bit positions and the fp_ALUCtrl codes of the
// multi-cycle ops (the same values ctrl_unit drives).
package fp_mc_seq_pkg;

  // Sequencer states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_WB    = 2'b11
  } state_e;

  // RISC-V canonical quiet NaN, written back when the unit never answers.
  localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;

  // fflags layout {NV,DZ,OF,UF,NX}.
  localparam int unsigned FFLAG_W  = 5;
  localparam int unsigned FFLAG_NV = 4;

  // Flags reported for a timeout abort: invalid operation only.
  localparam logic [FFLAG_W-1:0] FFLAGS_TIMEOUT = FFLAG_W'(1) << FFLAG_NV;

  // fp_ALUCtrl codes of the ops routed through this sequencer.
  localparam logic [3:0] FP_OP_FDIV  = 4'd3;
  localparam logic [3:0] FP_OP_FSQRT = 4'd4;

endpackage

// File: rtl/fp_mc_seq_timer.sv
// Wait-cycle counter for the multi-cycle FP sequencer. Cleared on issue,
// advanced once per WAIT cycle, and flags expiry on its last allowed cycle.
module fp_mc_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear has priority over increment.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fp_mc_seq.sv
// Sequencer for multi-cycle FP ops (fdiv.s, fsqrt.s). Freezes the fetch PC
// while an op is in flight, latches operands and rd, pulses start to the
// iterative unit, waits for done or a timeout, then issues a one-cycle FP
// register-file write and accrues fflags.
module fp_mc_seq
  import fp_mc_seq_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned OPW     = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  input  logic [OPW-1:0]     op_code,
  input  logic [4:0]         op_rd,
  input  logic [XLEN-1:0]    op_a,
  input  logic [XLEN-1:0]    op_b,
  output logic               unit_start,
  output logic [OPW-1:0]     unit_op,
  output logic [XLEN-1:0]    unit_a,
  output logic [XLEN-1:0]    unit_b,
  input  logic               unit_done,
  input  logic [XLEN-1:0]    unit_result,
  input  logic [FFLAG_W-1:0] unit_flags,
  output logic               stall,
  output logic               wb_en,
  output logic [4:0]         wb_rd,
  output logic [XLEN-1:0]    wb_data,
  input  logic               fflags_clr,
  output logic [FFLAG_W-1:0] fflags_acc,
  output logic               timeout_err
);

  state_e             state_q,  state_d;
  logic [OPW-1:0]     op_q,     op_d;
  logic [4:0]         rd_q,     rd_d;
  logic [XLEN-1:0]    a_q,      a_d;
  logic [XLEN-1:0]    b_q,      b_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic [FFLAG_W-1:0] flags_q,  flags_d;
  logic [FFLAG_W-1:0] acc_q,    acc_d;
  logic               terr_q,   terr_d;

  logic timer_clr;
  logic timer_en;
  logic timer_expire;

  fp_mc_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .clr_i    (timer_clr),
    .en_i     (timer_en),
    .expire_o (timer_expire)
  );

  // Next-state, operand capture, result capture and flag accrual.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    flags_d   = flags_q;
    acc_d     = acc_q;
    terr_d    = terr_q;
    timer_clr = 1'b0;
    timer_en  = 1'b0;

    // A clear outside WB simply empties the accumulator.
    if (fflags_clr) begin
      acc_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          op_d    = op_code;
          rd_d    = op_rd;
          a_d     = op_a;
          b_d     = op_b;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_clr = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // A real answer on the last allowed cycle still beats the abort.
        if (unit_done) begin
          result_d = unit_result;
          flags_d  = unit_flags;
          state_d  = ST_WB;
        end else if (timer_expire) begin
          result_d = XLEN'(FP_CANON_NAN);
          flags_d  = FFLAGS_TIMEOUT;
          terr_d   = 1'b1;
          state_d  = ST_WB;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_WB: begin
        // Clear applies before the retiring op's flags are merged in.
        acc_d   = (fflags_clr ? '0 : acc_q) | flags_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every register here is a handful of flops, not a memory, so all
    // of them are reset and no X ever reaches the unit or the regfile.
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
      acc_q    <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      acc_q    <= acc_d;
      terr_q   <= terr_d;
    end
  end

  assign unit_start  = (state_q == ST_ISSUE);
  assign wb_en       = (state_q == ST_WB);
  // The accepting IDLE cycle already stalls so the PC never advances past
  // the op; gating with reset keeps the core free while reset is held.
  assign stall       = reset & (((state_q == ST_IDLE) & op_valid)
                                | (state_q == ST_ISSUE)
                                | (state_q == ST_WAIT));
  assign unit_op     = op_q;
  assign unit_a      = a_q;
  assign unit_b      = b_q;
  assign wb_rd       = rd_q;
  assign wb_data     = result_q;
  assign fflags_acc  = acc_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_fp_mc_seq.sv
// Self-checking bench for fp_mc_seq: directed vector table, hand-written
// reset / spurious-done / flag-clear sequences, and randomized ops checked
// against a cycle-count model of the sequencer.
module tb_fp_mc_seq;
  import fp_mc_seq_pkg::*;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [3:0]  op_code;
  logic [4:0]  op_rd;
  logic [31:0] op_a, op_b;
  logic        unit_start;
  logic [3:0]  unit_op;
  logic [31:0] unit_a, unit_b;
  logic        unit_done;
  logic [31:0] unit_result;
  logic [4:0]  unit_flags;
  logic        stall, wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fflags_clr;
  logic [4:0]  fflags_acc;
  logic        timeout_err;

  fp_mc_seq #(.XLEN(32), .OPW(4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_code(op_code), .op_rd(op_rd), .op_a(op_a), .op_b(op_b),
    .unit_start(unit_start), .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
    .unit_done(unit_done), .unit_result(unit_result), .unit_flags(unit_flags),
    .stall(stall), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .fflags_clr(fflags_clr), .fflags_acc(fflags_acc), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // One op as seen by the bench: done_at is the cycle (op_valid cycle = 0)
  // at which a single done pulse is driven; -1 means never.
  typedef struct {
    logic [4:0]  rd;
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    int          done_at;
    logic [31:0] res;
    logic [4:0]  flags;
    bit          clr;
    bit          hold;
  } op_t;

  typedef struct {
    int          wb;
    logic [31:0] data;
    logic [4:0]  acc;
    bit          terr;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t ex;
  } vec_t;

  int       n_checks = 0;
  int       n_pass   = 0;
  logic [4:0] acc_m  = '0;
  bit       terr_m   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Reference model: WAIT occupies cycles 2..TO+1; a done pulse there is
  // taken and written back the next cycle, otherwise the abort writes back
  // after the last WAIT cycle.
  function automatic exp_t model(input op_t op);
    exp_t e;
    bit took;
    logic [4:0] f;
    took   = (op.done_at >= 2) && (op.done_at <= int'(TO) + 1);
    e.wb   = took ? op.done_at + 1 : int'(TO) + 2;
    e.data = took ? op.res : FP_CANON_NAN;
    f      = took ? op.flags : 5'b10000;
    acc_m  = (op.clr ? 5'b0 : acc_m) | f;
    terr_m = terr_m | !took;
    e.acc  = acc_m;
    e.terr = terr_m;
    return e;
  endfunction

  task automatic idle_inputs();
    op_valid   = 1'b0;
    unit_done  = 1'b0;
    fflags_clr = 1'b0;
  endtask

  // Drives one op from its op_valid cycle through WB; returns at WB+1 (+1).
  task automatic run_op(input string tag, input op_t op, input exp_t ex);
    int c = 0;
    int seen = -1;
    int n_start = 0;
    int first_start = -1;
    int n_stall = 0;
    logic s_stall = 1'bx;
    logic [4:0]  s_rd = 'x;
    logic [3:0]  s_op = 'x;
    logic [31:0] s_data = 'x, s_a = 'x, s_b = 'x;
    while (seen < 0 && c <= int'(TO) + 5) begin
      op_valid    = (c == 0) || (op.hold && c <= ex.wb);
      op_code     = (c == 0) ? op.code : 4'($urandom);
      op_rd       = (c == 0) ? op.rd   : 5'($urandom);
      op_a        = (c == 0) ? op.a    : $urandom;
      op_b        = (c == 0) ? op.b    : $urandom;
      unit_done   = (c == op.done_at);
      unit_result = (c == op.done_at) ? op.res   : $urandom;
      unit_flags  = (c == op.done_at) ? op.flags : 5'($urandom);
      fflags_clr  = op.clr && (c == ex.wb);
      @(negedge clk);
      if (stall) n_stall++;
      if (unit_start) begin
        n_start++;
        if (first_start < 0) first_start = c;
      end
      if (wb_en) begin
        seen = c; s_stall = stall; s_rd = wb_rd; s_data = wb_data;
        s_op = unit_op; s_a = unit_a; s_b = unit_b;
      end
      @(posedge clk); #1;
      c++;
    end
    idle_inputs();
    check({tag, " start_count"}, n_start, 1);
    check({tag, " start_cycle"}, first_start, 1);
    check({tag, " wb_cycle"}, seen, ex.wb);
    check({tag, " stall_cycles"}, n_stall, ex.wb);
    check({tag, " stall_in_wb"}, {31'b0, s_stall}, 0);
    check({tag, " wb_rd"}, {27'b0, s_rd}, {27'b0, op.rd});
    check({tag, " wb_data"}, s_data, ex.data);
    check({tag, " unit_op"}, {28'b0, s_op}, {28'b0, op.code});
    check({tag, " unit_a"}, s_a, op.a);
    check({tag, " unit_b"}, s_b, op.b);
    check({tag, " fflags_acc"}, {27'b0, fflags_acc}, {27'b0, ex.acc});
    check({tag, " timeout_err"}, {31'b0, timeout_err}, {31'b0, ex.terr});
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{'{5'd5, FP_OP_FDIV, 32'h40C00000, 32'h40000000, 5, 32'h40400000, 5'b00000, 1'b0, 1'b1},
                '{6, 32'h40400000, 5'b00000, 1'b0}};
    vecs[1] = '{'{5'd1, FP_OP_FSQRT, 32'h40800000, 32'h0, 2, 32'h40000000, 5'b00001, 1'b0, 1'b0},
                '{3, 32'h40000000, 5'b00001, 1'b0}};
    vecs[2] = '{'{5'd7, FP_OP_FDIV, 32'h3F800000, 32'h0, -1, 32'h12345678, 5'b01000, 1'b1, 1'b0},
                '{10, 32'h7FC00000, 5'b10000, 1'b1}};
    vecs[3] = '{'{5'd9, FP_OP_FSQRT, 32'hBF800000, 32'h0, 1, 32'h3F800000, 5'b00001, 1'b1, 1'b1},
                '{10, 32'h7FC00000, 5'b10000, 1'b1}};
    vecs[4] = '{'{5'd12, FP_OP_FDIV, 32'h3F800000, 32'h40400000, 3, 32'h3EAAAAAB, 5'b00100, 1'b1, 1'b0},
                '{4, 32'h3EAAAAAB, 5'b00100, 1'b1}};
    vecs[5] = '{'{5'd31, FP_OP_FDIV, 32'h41200000, 32'h40A00000, 4, 32'h40000000, 5'b00001, 1'b1, 1'b0},
                '{5, 32'h40000000, 5'b00001, 1'b1}};
    vecs[6] = '{'{5'd0, FP_OP_FSQRT, 32'h41100000, 32'h0, 9, 32'h40400000, 5'b00010, 1'b0, 1'b0},
                '{10, 32'h40400000, 5'b00011, 1'b1}};

    // Reset held with op_valid high: nothing may stall or fire.
    reset = 1'b0; op_valid = 1'b1; op_code = '0; op_rd = '0; op_a = '0; op_b = '0;
    unit_done = 1'b0; unit_result = '0; unit_flags = '0; fflags_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst stall", {31'b0, stall}, 0);
    check("rst unit_start", {31'b0, unit_start}, 0);
    check("rst wb_en", {31'b0, wb_en}, 0);
    check("rst fflags_acc", {27'b0, fflags_acc}, 0);
    check("rst timeout_err", {31'b0, timeout_err}, 0);
    check("rst wb_data", wb_data, 0);
    op_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    // Spurious done while idle is ignored.
    for (int i = 0; i < 2; i++) begin
      unit_done = 1'b1; unit_result = 32'hDEADBEEF; unit_flags = 5'b11111;
      @(negedge clk);
      check($sformatf("idle_done%0d wb_en", i), {31'b0, wb_en}, 0);
      check($sformatf("idle_done%0d stall", i), {31'b0, stall}, 0);
      @(posedge clk); #1;
    end
    idle_inputs();
    @(posedge clk); #1;
    check("idle_done acc", {27'b0, fflags_acc}, 0);

    // Directed table, issued back to back.
    for (int i = 0; i < 7; i++) begin
      exp_t unused_e;
      unused_e = model(vecs[i].op);
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].ex);
    end

    // fflags_clr with no write-back empties the accumulator.
    fflags_clr = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    acc_m = '0;
    check("clr_alone acc", {27'b0, fflags_acc}, 0);
    check("clr_alone terr_sticky", {31'b0, timeout_err}, 1);

    // Randomized ops against the model, with random idle gaps.
    for (int n = 0; n < 30; n++) begin
      op_t  op;
      exp_t ex;
      int gap;
      op.rd      = 5'($urandom);
      op.code    = ($urandom_range(0, 1) == 0) ? FP_OP_FDIV : FP_OP_FSQRT;
      op.a       = $urandom;
      op.b       = $urandom;
      op.done_at = $urandom_range(0, TO + 3);
      op.res     = $urandom;
      op.flags   = 5'($urandom);
      op.clr     = ($urandom_range(0, 3) == 0);
      op.hold    = $urandom_range(0, 1) == 1;
      ex = model(op);
      run_op($sformatf("rnd%0d", n), op, ex);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        unit_done = $urandom_range(0, 1) == 1;
        @(negedge clk);
        check($sformatf("rnd%0d gap%0d wb_en", n, g), {31'b0, wb_en}, 0);
        @(posedge clk); #1;
      end
      idle_inputs();
    end

    // Reset asserted mid-WAIT, then a late done after release.
    op_valid = 1'b1; op_rd = 5'd3; op_a = 32'h1; op_b = 32'h2;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midwait stall_before", {31'b0, stall}, 1);
    reset = 1'b0; op_valid = 1'b1;
    #1;
    check("midwait stall", {31'b0, stall}, 0);
    check("midwait unit_start", {31'b0, unit_start}, 0);
    check("midwait wb_en", {31'b0, wb_en}, 0);
    check("midwait acc", {27'b0, fflags_acc}, 0);
    check("midwait terr", {31'b0, timeout_err}, 0);
    @(posedge clk); #1;
    op_valid = 1'b0;
    reset = 1'b1;
    acc_m = '0; terr_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      unit_done = 1'b1; unit_result = 32'hCAFEF00D;
      @(negedge clk);
      check($sformatf("late_done%0d wb_en", i), {31'b0, wb_en}, 0);
      check($sformatf("late_done%0d stall", i), {31'b0, stall}, 0);
      @(posedge clk); #1;
    end
    idle_inputs();

    // The sequencer recovers cleanly after the reset.
    begin
      op_t  op;
      exp_t ex;
      op = '{5'd17, FP_OP_FDIV, 32'h40000000, 32'h40000000, 2, 32'h3F800000, 5'b00000, 1'b0, 1'b0};
      ex = model(op);
      run_op("post_reset", op, ex);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
